// File: rtl/xeng_offset_corr_apply_pkg.sv
// Shared lane ordering and offset-correction constants for the X-engine correction path.
// No logic; latency n/a; backpressure n/a.
package xeng_offset_corr_apply_pkg;

  localparam int NUM_LANES  = 8;

  // Lane index 0 is the most significant slice of every 8-lane bus.
  localparam int LANE_RE_XX = 0;
  localparam int LANE_IM_XX = 1;
  localparam int LANE_RE_XY = 2;
  localparam int LANE_IM_XY = 3;
  localparam int LANE_RE_YX = 4;
  localparam int LANE_IM_YX = 5;
  localparam int LANE_RE_YY = 6;
  localparam int LANE_IM_YY = 7;

  // log2 of the constant term left by the offset-binary real parts: N * O^2
  function automatic int k_shift(input int acc_len_bits, input int bitwidth);
    return acc_len_bits + 2 * (bitwidth - 1);
  endfunction

  function automatic bit lane_is_re(input int lane);
    return (lane % 2) == 0;
  endfunction

endpackage

// File: rtl/xeng_offset_corr_apply_sync_fifo.sv
// Generic first-word-fall-through FIFO with synchronous clear and occupancy output.
// Latency: head visible the cycle after the push; level updates the cycle after push/pop.
// Backpressure: none; push while full is dropped unless a pop frees the slot the same cycle.
module sync_fifo #(
  parameter int WIDTH      = 128,
  parameter int DEPTH_BITS = 5
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_BITS:0]   level
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_BITS:0] wptr;
  logic [DEPTH_BITS:0] rptr;
  logic                do_push;
  logic                do_pop;

  // Extra pointer MSB tells a full ring from an empty one.
  assign empty = (wptr == rptr);
  assign full  = (wptr[DEPTH_BITS] != rptr[DEPTH_BITS]) &&
                 (wptr[DEPTH_BITS-1:0] == rptr[DEPTH_BITS-1:0]);
  assign level = wptr - rptr;
  assign dout  = mem[rptr[DEPTH_BITS-1:0]];

  // A pop from an empty ring never returns the word being pushed alongside it.
  assign do_pop  = rd_en && !empty && !clr;
  assign do_push = wr_en && (!full || do_pop) && !clr;

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[DEPTH_BITS-1:0]] <= din;
  end

endmodule

// File: rtl/xeng_offset_corr_apply.sv
// Removes offset-binary cross terms from raw X-engine accumulations using queued per-baseline corrections.
// Latency: 2 clocks xeng_vld -> dout_vld, 1 word/clock; no backpressure, FIFO over/underflow only set sticky flags.
module xeng_offset_corr_apply
  import xeng_offset_corr_apply_pkg::*;
#(
  parameter int BITWIDTH        = 4,
  parameter int XENG_WIDTH      = 32,
  parameter int CORR_WIDTH      = 16,
  parameter int ACC_LEN_BITS    = 9,
  parameter int FIFO_DEPTH_BITS = 5,
  parameter int OUT_WIDTH       = XENG_WIDTH + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sync,
  input  logic [NUM_LANES*CORR_WIDTH-1:0]   corr_din,
  input  logic                              corr_vld,
  input  logic [NUM_LANES*XENG_WIDTH-1:0]   xeng_din,
  input  logic                              xeng_vld,
  output logic [NUM_LANES*OUT_WIDTH-1:0]    dout,
  output logic                              dout_vld,
  output logic [FIFO_DEPTH_BITS:0]          fifo_level,
  output logic                              ovf,
  output logic                              unf
);

  localparam int SHIFT   = BITWIDTH - 1;
  localparam int K_SHIFT = k_shift(ACC_LEN_BITS, BITWIDTH);
  localparam logic signed [OUT_WIDTH-1:0] K_VAL = {{(OUT_WIDTH-1){1'b0}}, 1'b1} << K_SHIFT;

  logic                            clr;
  logic [NUM_LANES*CORR_WIDTH-1:0] fifo_dout;
  logic [NUM_LANES*CORR_WIDTH-1:0] corr_head;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic                            pop_ok;
  logic                            push_drop;
  logic                            pop_fail;
  logic                            s1_vld;

  assign clr = rst | sync;

  sync_fifo #(
    .WIDTH      (NUM_LANES * CORR_WIDTH),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_corr_fifo (
    .clk   (clk),
    .clr   (clr),
    .wr_en (corr_vld),
    .din   (corr_din),
    .rd_en (xeng_vld),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // An unmatched X-eng word is passed through with zero corrections.
  assign corr_head = fifo_empty ? '0 : fifo_dout;
  assign pop_ok    = xeng_vld && !fifo_empty;
  assign push_drop = corr_vld && fifo_full && !pop_ok;
  assign pop_fail  = xeng_vld && fifo_empty;

  always_ff @(posedge clk) begin
    if (clr) begin
      ovf      <= 1'b0;
      unf      <= 1'b0;
      s1_vld   <= 1'b0;
      dout_vld <= 1'b0;
    end else begin
      if (push_drop) ovf <= 1'b1;
      if (pop_fail)  unf <= 1'b1;
      s1_vld   <= xeng_vld;
      dout_vld <= s1_vld;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam int XHI   = (NUM_LANES - l) * XENG_WIDTH - 1;
    localparam int CHI   = (NUM_LANES - l) * CORR_WIDTH - 1;
    localparam int OHI   = (NUM_LANES - l) * OUT_WIDTH - 1;
    localparam bit IS_RE = lane_is_re(l);

    logic signed [OUT_WIDTH-1:0] x_ext;
    logic signed [OUT_WIDTH-1:0] c_ext;
    logic signed [OUT_WIDTH-1:0] s1_nxt;
    logic signed [OUT_WIDTH-1:0] s1_q;
    logic signed [OUT_WIDTH-1:0] dout_q;

    assign x_ext  = {{(OUT_WIDTH-XENG_WIDTH){xeng_din[XHI]}}, xeng_din[XHI -: XENG_WIDTH]};
    assign c_ext  = {{(OUT_WIDTH-CORR_WIDTH){corr_head[CHI]}}, corr_head[CHI -: CORR_WIDTH]};
    assign s1_nxt = x_ext - (c_ext <<< SHIFT);

    // Only real lanes carry the N*O^2 term; dout holds between valid words.
    always_ff @(posedge clk) begin
      if (clr) begin
        s1_q   <= '0;
        dout_q <= '0;
      end else begin
        if (xeng_vld) s1_q <= s1_nxt;
        if (s1_vld)   dout_q <= IS_RE ? (s1_q - K_VAL) : s1_q;
      end
    end

    assign dout[OHI -: OUT_WIDTH] = dout_q;
  end

endmodule

// File: tb/tb_xeng_offset_corr_apply.sv
// Directed + randomized bench for xeng_offset_corr_apply against a queue-based reference model.
module tb_xeng_offset_corr_apply;

  logic         clk = 1'b0;
  logic         rst;
  logic         sync;
  logic [127:0] corr_din;
  logic         corr_vld;
  logic [255:0] xeng_din;
  logic         xeng_vld;
  logic [263:0] dout;
  logic         dout_vld;
  logic [5:0]   fifo_level;
  logic         ovf;
  logic         unf;

  int tests = 0;
  int fails = 0;

  // Reference state: queued correction sets, sticky flags, and two pipeline stages of finished results.
  logic [127:0] q[$];
  bit           m_ovf;
  bit           m_unf;
  bit           m_s1_vld;
  bit           m_vld;
  logic [263:0] m_s1;
  logic [263:0] m_dout;

  xeng_offset_corr_apply dut (
    .clk        (clk),
    .rst        (rst),
    .sync       (sync),
    .corr_din   (corr_din),
    .corr_vld   (corr_vld),
    .xeng_din   (xeng_din),
    .xeng_vld   (xeng_vld),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .fifo_level (fifo_level),
    .ovf        (ovf),
    .unf        (unf)
  );

  always #5 clk = ~clk;

  function automatic logic [263:0] expect_word(input logic [255:0] x, input logic [127:0] c);
    logic [263:0] r;
    longint       xi;
    longint       ci;
    longint       v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      xi = longint'($signed(x[(8-i)*32-1 -: 32]));
      ci = longint'($signed(c[(8-i)*16-1 -: 16]));
      v  = xi - ci * 8 - (((i % 2) == 0) ? 64'sd32768 : 64'sd0);
      r[(8-i)*33-1 -: 33] = v[32:0];
    end
    return r;
  endfunction

  function automatic logic [32:0] lane_of(input logic [263:0] d, input int i);
    return d[(8-i)*33-1 -: 33];
  endfunction

  function automatic logic [127:0] rand_corr();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand_xeng();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [263:0] obs, input logic [263:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit cv, input logic [127:0] cd,
                      input bit xv, input logic [255:0] xd);
    logic [127:0] c;
    bit           popped;
    rst = r; sync = s; corr_vld = cv; corr_din = cd; xeng_vld = xv; xeng_din = xd;
    @(posedge clk);
    if (r || s) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_s1_vld = 0; m_vld = 0; m_dout = '0;
    end else begin
      popped = xv && (q.size() > 0);
      c = popped ? q[0] : '0;
      if (xv && !popped) m_unf = 1;
      if (m_s1_vld) m_dout = m_s1;
      m_vld    = m_s1_vld;
      m_s1_vld = xv;
      if (xv) m_s1 = expect_word(xd, c);
      if (popped) void'(q.pop_front());
      if (cv) begin
        if (q.size() < 32) q.push_back(cd);
        else m_ovf = 1;
      end
    end
    #1;
    check("dout_vld", 264'(dout_vld), 264'(m_vld));
    check("dout", dout, m_dout);
    check("fifo_level", 264'(fifo_level), 264'(q.size()));
    check("ovf", 264'(ovf), 264'(m_ovf));
    check("unf", 264'(unf), 264'(m_unf));
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 0, '0);
  endtask

  task automatic do_sync();
    step(0, 1, 1, rand_corr(), 1, rand_xeng());
  endtask

  logic [127:0] cd;
  logic [255:0] xd;

  initial begin
    rst = 1'b1; sync = 1'b0; corr_vld = 1'b0; xeng_vld = 1'b0; corr_din = '0; xeng_din = '0;

    // reset with valids asserted: everything discarded
    step(1, 0, 1, rand_corr(), 1, rand_xeng());
    step(1, 0, 1, rand_corr(), 1, rand_xeng());
    idle();

    // single word
    cd = '0; cd[127:112] = 16'd5; cd[111:96] = 16'hFFFE;
    xd = '0; xd[255:224] = 32'd40000; xd[223:192] = 32'd100;
    step(0, 0, 1, cd, 0, '0);
    step(0, 0, 0, '0, 1, xd);
    idle();
    check("single_re_xx", 264'(lane_of(dout, 0)), 264'(33'd7192));
    check("single_im_xx", 264'(lane_of(dout, 1)), 264'(33'd116));
    check("single_vld", 264'(dout_vld), 264'(1'b1));
    idle();
    check("single_pulse", 264'(dout_vld), 264'(1'b0));

    // streaming
    do_sync();
    for (int i = 0; i < 32; i++) step(0, 0, 1, rand_corr(), 0, '0);
    for (int i = 0; i < 32; i++) step(0, 0, 0, '0, 1, rand_xeng());
    idle(); idle();
    check("stream_level", 264'(fifo_level), 264'(0));

    // overflow
    do_sync();
    for (int i = 0; i < 33; i++) step(0, 0, 1, rand_corr(), 0, '0);
    check("ovf_level", 264'(fifo_level), 264'(32));
    check("ovf_flag", 264'(ovf), 264'(1'b1));
    for (int i = 0; i < 32; i++) step(0, 0, 0, '0, 1, rand_xeng());
    idle(); idle();
    check("ovf_unf_clear", 264'(unf), 264'(1'b0));

    // underflow
    do_sync();
    xd = '0; xd[63:32] = 32'd32768; xd[31:0] = 32'hFFFF_FFF9;
    step(0, 0, 0, '0, 1, xd);
    idle();
    cd = '0;
    cd[32:0] = 33'h1_FFFF_FFF9;
    check("unf_re_yy", 264'(lane_of(dout, 6)), 264'(33'd0));
    check("unf_im_yy", 264'(lane_of(dout, 7)), 264'(cd[32:0]));
    check("unf_flag", 264'(unf), 264'(1'b1));

    // simultaneous push+pop on empty
    do_sync();
    step(0, 0, 1, rand_corr(), 1, rand_xeng());
    check("both_empty_unf", 264'(unf), 264'(1'b1));
    check("both_empty_level", 264'(fifo_level), 264'(1));
    idle(); idle();

    // simultaneous push+pop on full
    do_sync();
    for (int i = 0; i < 32; i++) step(0, 0, 1, rand_corr(), 0, '0);
    step(0, 0, 1, rand_corr(), 1, rand_xeng());
    check("both_full_ovf", 264'(ovf), 264'(1'b0));
    check("both_full_level", 264'(fifo_level), 264'(32));
    for (int i = 0; i < 34; i++) step(0, 0, 0, '0, 1, rand_xeng());
    idle(); idle();

    // sync mid-stream with in-flight results
    do_sync();
    for (int i = 0; i < 10; i++) step(0, 0, 1, rand_corr(), 0, '0);
    step(0, 0, 0, '0, 1, rand_xeng());
    step(0, 0, 0, '0, 1, rand_xeng());
    do_sync();
    check("sync_level", 264'(fifo_level), 264'(0));
    idle();
    check("sync_drop_vld", 264'(dout_vld), 264'(1'b0));
    step(0, 0, 1, rand_corr(), 0, '0);
    step(0, 0, 0, '0, 1, rand_xeng());
    idle(); idle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 127) == 0), ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 99) < 55), rand_corr(),
           ($urandom_range(0, 99) < 50), rand_xeng());
    end
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
